ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
//  It sits beside the existing PS/2 receive path, which stays unchanged. Top level ties it to the shared
//  ps2_clk/ps2_data inout pads as open-drain: pad = oe ? 1'b0 : 1'bz.

---
 rtl/ps2_host_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter (open-drain, system clock domain)
//
// Sends one command byte to a PS/2 device. The frame is an inhibit, then a
// request-to-send, then 10 device-clocked bits, then the device ack.
// The top level maps each *_oe output to its pad as: pad = oe ? 1'b0 : 1'bz.
// This block never drives a line high.
//
// Ports
//   clk          in   100 MHz system clock
//   reset        in   asynchronous active-low reset
//   tx_data      in   [7:0] byte to send, captured on tx_valid && tx_ready
//   tx_valid     in   send request (ignored while busy, not queued)
//   tx_ready     out  high only while idle
//   busy         out  high whenever not idle
//   done         out  one-cycle pulse: frame sent and ack received
//   err          out  one-cycle pulse: frame aborted
//   err_code     out  [1:0] with err: 1 start timeout, 2 frame timeout, 3 no ack
//   ps2_clk_in   in   raw ps2_clk pad level (asynchronous)
//   ps2_data_in  in   raw ps2_data pad level (asynchronous)
//   ps2_clk_oe   out  1 = pull ps2_clk low
//   ps2_data_oe  out  1 = pull ps2_data low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned FRAME_TIMEOUT  = 200000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TMAX_A = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > INHIBIT_CYCLES) ? TMAX_A : INHIBIT_CYCLES;
    localparam int unsigned TW     = $clog2(TMAX + 2);
    localparam int unsigned FW     = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_ABORT
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronizers and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall_q;

    // filt_q follows the synced clock only after FILTER_LEN consecutive
    // differing samples; fall_q pulses in the first cycle filt_q reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync_q[1];
                fcnt_q <= '0;
                fall_q <= ~clk_sync_q[1];
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_sat;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic [1:0]    code_q, code_d;
    logic          done_q, done_d;
    logic          abort;
    logic [1:0]    abort_code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            code_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            code_q    <= code_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        code_d     = code_q;
        done_d     = 1'b0;
        abort      = 1'b0;
        abort_code = 2'd0;
        timer_sat  = (timer_q == '1) ? timer_q : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    // {stop, odd parity, d7..d0}; bit 0 goes out first
                    shift_d  = {1'b1, ~^tx_data, tx_data};
                    timer_d  = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                timer_d = timer_sat;
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                end
                if (timer_q >= TW'(INHIBIT_CYCLES)) begin
                    clk_oe_d = 1'b0;
                    timer_d  = '0;
                    state_d  = S_RTS;
                end
            end
            S_RTS: begin
                if (fall_q) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bitcnt_d  = 4'd1;
                    timer_d   = '0;
                    state_d   = S_SHIFT;
                end else if (timer_q >= TW'(START_TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    abort_code = 2'd1;
                end else begin
                    timer_d = timer_sat;
                end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                timer_d = timer_sat;
                // Frame timeout wins over a fall in the same cycle.
                if (timer_q >= TW'(FRAME_TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end else if (state_q == S_SHIFT) begin
                    if (fall_q) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                        bitcnt_d  = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall_q) begin
                        if (data_sync_q[1]) begin
                            abort      = 1'b1;
                            abort_code = 2'd3;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end else begin
                    if (filt_q && data_sync_q[1]) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            code_d    = abort_code;
            state_d   = S_ABORT;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = (state_q == S_ABORT);
    assign err_code    = (state_q == S_ABORT) ? code_q : 2'd0;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int unsigned IC   = 200;
    localparam int unsigned ST   = 3000;
    localparam int unsigned FT   = 6000;
    localparam int unsigned FL   = 8;
    localparam int unsigned HALF = 30;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NOCLK  = 1;
    localparam int MODE_STALL  = 2;
    localparam int MODE_NOACK  = 3;
    localparam int MODE_RESET  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low, glitch_low;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host, device and glitch injector
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(IC),
        .START_TIMEOUT (ST),
        .FRAME_TIMEOUT (FT),
        .FILTER_LEN    (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] wire_bits;
    int         wire_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Odd parity: parity bit makes the total number of ones odd
    function automatic logic model_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return ((ones % 2) == 0);
    endfunction

    // Monitor: pops one expectation per done/err pulse
    always @(negedge clk) begin
        if (reset && (done || err)) begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: done=%0b err=%0b code=%0d, nothing expected", done, err, err_code);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_kind_err", 32'(err), 32'(mon_e.is_err));
                chk("err_code", 32'(err_code), mon_e.is_err ? 32'(mon_e.code) : 32'd0);
                if (mon_e.is_err) begin
                    chk("oe_released_on_err", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                end else begin
                    chk("wire_bit_count", 32'(wire_cnt), 32'd10);
                    chk("wire_byte", 32'(wire_bits[7:0]), 32'(mon_e.data));
                    chk("wire_parity", 32'(wire_bits[8]), 32'(model_parity(mon_e.data)));
                    chk("wire_stop", 32'(wire_bits[9]), 32'd1);
                    chk("ready_after_done", 32'(tx_ready), 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d, input bit is_err, input logic [1:0] code);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.data   = d;
        @(negedge clk);
        chk("tx_ready_before_issue", 32'(tx_ready), 32'd1);
        sb.push_back(e);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_drops", 32'(tx_ready), 32'd0);
        chk("busy_rises", 32'(busy), 32'd1);
    endtask

    // Device model: waits for request-to-send, clocks the frame in,
    // records the 10 bits seen at each rising edge, then acks.
    task automatic device(input int mode, input bit glitch);
        int t = 0;
        int inh = 0;
        wire_cnt  = 0;
        wire_bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < int'(IC) + 1000) begin
            @(negedge clk);
            if (ps2_clk_oe) inh++;
            t++;
        end
        chk("rts_seen", 32'(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1), 32'd1);
        chk("inhibit_len_ok", 32'(inh >= int'(IC) && inh <= int'(IC) + 2), 32'd1);
        if (mode == MODE_NOCLK) return;
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (mode == MODE_STALL && i == 6) return;
            if (i == 11 && mode != MODE_NOACK) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (mode == MODE_RESET && i == 4) begin
                #2 reset = 1'b0;
                #1;
                chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
                chk("reset_tx_ready", 32'(tx_ready), 32'd1);
                chk("reset_busy", 32'(busy), 32'd0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                sb.delete();
                repeat (3) @(negedge clk);
                reset = 1'b1;
                repeat (20) @(negedge clk);
                return;
            end
            dev_clk_low = 1'b0;
            if (i <= 10) begin
                wire_bits[i-1] = ps2_data_in;
                wire_cnt++;
            end
            if (i == 11) dev_data_low = 1'b0;
            if (glitch && i <= 9) begin
                repeat (5) @(negedge clk);
                glitch_low = 1'b1;
                repeat (3) @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 8) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_empty(input int max_cycles);
        int t = 0;
        while (sb.size() != 0 && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        chk("response_received", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] d, input bit glitch);
        issue(d, 1'b0, 2'd0);
        device(MODE_NORMAL, glitch);
        wait_empty(200);
    endtask

    initial begin
        int cnt;
        int act;
        logic [7:0] d;
        reset        = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        glitch_low   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send_ok(8'hED, 1'b0);
        send_ok(8'h00, 1'b0);
        send_ok(8'hFF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            send_ok(d, k[0]);
        end
        send_ok(8'hA5, 1'b1);

        // Device never clocks: start timeout counted from RTS entry
        issue(8'($urandom_range(0, 255)), 1'b1, 2'd1);
        device(MODE_NOCLK, 1'b0);
        cnt = 0;
        while (!err && cnt < int'(ST) + 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("start_timeout_cycles", 32'(cnt), 32'(ST));
        @(negedge clk);
        chk("oe_after_start_timeout", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        wait_empty(10);

        issue(8'($urandom_range(0, 255)), 1'b1, 2'd3);
        device(MODE_NOACK, 1'b0);
        wait_empty(200);

        issue(8'($urandom_range(0, 255)), 1'b1, 2'd2);
        device(MODE_STALL, 1'b0);
        wait_empty(int'(FT) + 500);
        chk("oe_after_frame_timeout", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        // Second request while busy must be dropped
        issue(8'hF4, 1'b0, 2'd0);
        fork
            device(MODE_NORMAL, 1'b0);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h11;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_empty(200);
        act = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy || ps2_clk_oe) act++;
        end
        chk("no_queued_frame", 32'(act), 32'd0);

        // Reset during bit 4, then a clean frame
        issue(8'($urandom_range(0, 255)), 1'b0, 2'd0);
        device(MODE_RESET, 1'b0);
        chk("idle_after_reset", 32'(tx_ready), 32'd1);
        send_ok(8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #700000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
